// File: rtl/athena_hiscore_ram_writer_if.sv
// Byte stream handshake from the dataslot byte FIFO into the hi-score RAM writer.
interface athena_hiscore_ram_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_offset;
    logic [7:0] in_data;

    modport master (output in_valid, output in_offset, output in_data, input in_ready);
    modport slave  (input in_valid, input in_offset, input in_data, output in_ready);
endinterface

// File: rtl/athena_hiscore_ram_writer.sv
// Hi-score RAM writer: buffers slot bytes and writes them into the side RAM
// hi-score table while the CPU is paused, then reports completion.
module athena_hiscore_ram_writer #(
    parameter logic [10:0] BASE_ADDR     = 11'h650,
    parameter int unsigned LENGTH        = 114,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                          game_clk,
    input  logic                          reset_n,
    input  logic                          clear,
    athena_hiscore_ram_writer_if.slave    byte_in,
    input  logic                          pause_cpu,
    output logic                          ram_override,
    output logic [10:0]                   ram_addr,
    output logic [7:0]                    ram_data,
    output logic                          ram_nCS,
    output logic                          ram_nWE,
    output logic [6:0]                    bytes_written,
    output logic                          done,
    output logic                          range_err,
    output logic                          abort_err
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        ovr_q, ovr_d, ncs_q, ncs_d, nwe_q, nwe_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        done_q, done_d, rerr_q, rerr_d, aerr_q, aerr_d;
    logic        ready_q, ready_d;

    logic [10:0] fifo_addr_q [FIFO_DEPTH];
    logic [10:0] fifo_addr_d [FIFO_DEPTH];
    logic [7:0]  fifo_data_q [FIFO_DEPTH];
    logic [7:0]  fifo_data_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nxt_ptr;
    logic [PW:0]   count_q, count_d;

    logic full, accept, in_range, push, pop;

    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign accept   = byte_in.in_valid && byte_in.in_ready && !clear;
    assign in_range = (32'(byte_in.in_offset) < LENGTH);
    assign push     = accept && in_range;
    assign nxt_ptr  = rd_ptr_q + PW'(1);
    // A clear cycle always accepts (and drops) the offered byte.
    assign byte_in.in_ready = ready_q && (!full || clear);

    // Bus sequencer: next state, latched address/data, completion count and sticky flags.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        aerr_d  = aerr_q;
        pop     = 1'b0;
        ready_d = 1'b1;
        if (state_q != ST_IDLE && !pause_cpu) begin
            state_d = ST_IDLE;
            aerr_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0 && pause_cpu) begin
                        state_d = ST_SETUP;
                        cyc_d   = '0;
                        addr_d  = fifo_addr_q[rd_ptr_q];
                        data_d  = fifo_data_q[rd_ptr_q];
                    end
                end
                ST_SETUP: begin
                    if (cyc_q == SETUP_LAST) begin
                        state_d = ST_STROBE;
                        cyc_d   = '0;
                    end else begin
                        cyc_d = cyc_q + 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (cyc_q == STROBE_LAST) begin
                        state_d = ST_HOLD;
                        cyc_d   = '0;
                    end else begin
                        cyc_d = cyc_q + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cyc_q == HOLD_LAST) begin
                        pop   = 1'b1;
                        cnt_d = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
                        cyc_d = '0;
                        if (count_q >= (PW+1)'(2)) begin
                            state_d = ST_SETUP;
                            addr_d  = fifo_addr_q[nxt_ptr];
                            data_d  = fifo_data_q[nxt_ptr];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cyc_d = cyc_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            aerr_d  = 1'b0;
            pop     = 1'b0;
        end
        // Bus pins are registered from the next state so they change cleanly on the edge.
        ovr_d  = (state_d != ST_IDLE);
        ncs_d  = (state_d == ST_IDLE);
        nwe_d  = (state_d != ST_STROBE);
        done_d = (32'(cnt_d) >= LENGTH);
        rerr_d = clear ? 1'b0 : (rerr_q || (accept && !in_range));
    end

    // Input byte buffer: stores the resolved RAM address alongside each byte.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_addr_d[wr_ptr_q] = BASE_ADDR + 11'(byte_in.in_offset);
                fifo_data_d[wr_ptr_q] = byte_in.in_data;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = nxt_ptr;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, bus and buffer registers.
    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ovr_q    <= 1'b0;
            ncs_q    <= 1'b1;
            nwe_q    <= 1'b1;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            rerr_q   <= 1'b0;
            aerr_q   <= 1'b0;
            ready_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ovr_q       <= ovr_d;
            ncs_q       <= ncs_d;
            nwe_q       <= nwe_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            rerr_q      <= rerr_d;
            aerr_q      <= aerr_d;
            ready_q     <= ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign ram_override  = ovr_q;
    assign ram_addr      = addr_q;
    assign ram_data      = data_q;
    assign ram_nCS       = ncs_q;
    assign ram_nWE       = nwe_q;
    assign bytes_written = cnt_q;
    assign done          = done_q;
    assign range_err     = rerr_q;
    assign abort_err     = aerr_q;
endmodule

// File: tb/tb_athena_hiscore_ram_writer.sv
// Bench for the hi-score RAM writer: directed stimulus, expected RAM writes
// queued at acceptance and checked by a bus monitor as writes complete.
module tb_athena_hiscore_ram_writer;
    logic        clk, reset_n, clear, pause_cpu;
    logic        ram_override, ram_nCS, ram_nWE, done, range_err, abort_err;
    logic [10:0] ram_addr;
    logic [7:0]  ram_data;
    logic [6:0]  bytes_written;

    athena_hiscore_ram_writer_if bif ();

    athena_hiscore_ram_writer dut (
        .game_clk      (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .byte_in       (bif.slave),
        .pause_cpu     (pause_cpu),
        .ram_override  (ram_override),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .ram_nCS       (ram_nCS),
        .ram_nWE       (ram_nWE),
        .bytes_written (bytes_written),
        .done          (done),
        .range_err     (range_err),
        .abort_err     (abort_err)
    );

    typedef struct {
        logic [10:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ovr_falls = 0;
    bit   prev_nwe = 1'b1;
    bit   prev_ovr = 1'b0;
    int   slen = 0;
    logic [10:0] cap_addr;
    logic [7:0]  cap_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a completed write is a strobe ending with nCS still low.
    always @(negedge clk) begin
        if (prev_ovr && !ram_override) ovr_falls++;
        prev_ovr = ram_override;
        if (!ram_nWE) begin
            if (prev_nwe) begin
                cap_addr = ram_addr;
                cap_data = ram_data;
                slen = 1;
            end else begin
                slen++;
            end
        end else if (!prev_nwe && !ram_nCS) begin
            chk("strobe_len", slen, 2);
            chk("addr_stable", {ram_addr, ram_data}, {cap_addr, cap_data});
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", cap_addr, cap_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", cap_addr, e.a);
                chk("wr_data", cap_data, e.d);
            end
        end
        prev_nwe = ram_nWE;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] off, input logic [7:0] d, input bit expect_write);
        bit ok = 1'b0;
        bit acc;
        bif.in_valid  = 1'b1;
        bif.in_offset = off;
        bif.in_data   = d;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            acc = bif.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        bif.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got no accept for offset %0d, expected accept", off);
        end else if (expect_write) begin
            sb.push_back('{11'h650 + 11'(off), d});
        end
    endtask

    task automatic wait_bytes(input int target, input int limit, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (bytes_written == 7'(target)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got bytes_written %0d, expected %0d", name, bytes_written, target);
        end
    endtask

    task automatic wait_strobe(input logic [10:0] a, input bit any_addr, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!ram_nWE && (any_addr || ram_addr == a)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no strobe, expected strobe at %0h", name, a);
        end
    endtask

    task automatic pulse_clear();
        sync();
        clear = 1'b1;
        sync();
        clear = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        clear         = 1'b0;
        pause_cpu     = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_offset = '0;
        bif.in_data   = '0;
        repeat (3) @(negedge clk);
        chk("rst_override", ram_override, 0);
        chk("rst_nCS", ram_nCS, 1);
        chk("rst_nWE", ram_nWE, 1);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_flags", {bytes_written, done, range_err, abort_err}, 0);
        chk("rst_in_ready", bif.in_ready, 0);
        sync();
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", bif.in_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", bif.in_ready, 1);

        // Single byte: cycle-by-cycle bus sequence.
        pause_cpu = 1'b1;
        sync();
        push(7'd0, 8'hEB, 1'b1);
        @(negedge clk);
        chk("t1_idle_gap", ram_override, 0);
        @(negedge clk);
        chk("t1_setup_ovr", ram_override, 1);
        chk("t1_setup_addr", ram_addr, 11'h650);
        chk("t1_setup_data", ram_data, 8'hEB);
        chk("t1_setup_cs_we", {ram_nCS, ram_nWE}, 2'b01);
        @(negedge clk);
        chk("t1_strobe1", {ram_nCS, ram_nWE}, 2'b00);
        @(negedge clk);
        chk("t1_strobe2", {ram_nCS, ram_nWE}, 2'b00);
        @(negedge clk);
        chk("t1_hold", {ram_nCS, ram_nWE}, 2'b01);
        chk("t1_hold_count", bytes_written, 0);
        @(negedge clk);
        chk("t1_count", bytes_written, 1);
        chk("t1_release", {ram_override, ram_nCS, ram_nWE}, 3'b011);

        // Full table stream.
        pulse_clear();
        @(negedge clk);
        chk("t2_cleared", {bytes_written, done}, 0);
        begin
            int falls0;
            falls0 = ovr_falls;
            sync();
            for (int i = 0; i < 114; i++) push(7'(i), 8'(i) ^ 8'h5A, 1'b1);
            wait_bytes(113, 2000, "t2_wait113");
            chk("t2_done_early", done, 0);
            wait_bytes(114, 50, "t2_wait114");
            @(negedge clk);
            chk("t2_done", done, 1);
            chk("t2_range", range_err, 0);
            chk("t2_count", bytes_written, 114);
            chk("t2_override_held", ovr_falls - falls0, 1);
        end

        // Buffering with the CPU running.
        pause_cpu = 1'b0;
        pulse_clear();
        for (int i = 0; i < 4; i++) push(7'(i), 8'hA0 + 8'(i), 1'b1);
        bif.in_valid  = 1'b1;
        bif.in_offset = 7'd4;
        bif.in_data   = 8'hA4;
        repeat (2) @(negedge clk);
        chk("t3_full", bif.in_ready, 0);
        chk("t3_no_bus", {ram_override, ram_nCS}, 2'b01);
        sync();
        pause_cpu = 1'b1;
        push(7'd4, 8'hA4, 1'b1);
        wait_bytes(5, 200, "t3_drain");
        chk("t3_count", bytes_written, 5);

        // Pause dropped in the first strobe cycle of offset 3.
        pulse_clear();
        for (int i = 0; i < 4; i++) push(7'(i), 8'hC0 + 8'(i), 1'b1);
        wait_strobe(11'h653, 1'b0, "t4_strobe");
        pause_cpu = 1'b0;
        @(negedge clk);
        chk("t4_abort_bus", {ram_override, ram_nCS, ram_nWE}, 3'b011);
        chk("t4_abort_err", abort_err, 1);
        chk("t4_count_held", bytes_written, 3);
        repeat (3) @(negedge clk);
        chk("t4_idle", {ram_nCS, bytes_written}, {1'b1, 7'd3});
        pause_cpu = 1'b1;
        wait_bytes(4, 100, "t4_retry");
        chk("t4_abort_sticky", abort_err, 1);

        // Out-of-range offset.
        sync();
        push(7'd114, 8'h55, 1'b0);
        repeat (8) @(negedge clk);
        chk("t5_range_err", range_err, 1);
        chk("t5_count", bytes_written, 4);
        chk("t5_no_bus", ram_nCS, 1);

        // Clear in mid-strobe with three bytes queued and a byte offered.
        sync();
        for (int i = 0; i < 3; i++) push(7'd10 + 7'(i), 8'h31 + 8'(i), 1'b1);
        wait_strobe(11'h000, 1'b1, "t6_strobe");
        clear         = 1'b1;
        bif.in_valid  = 1'b1;
        bif.in_offset = 7'd20;
        bif.in_data   = 8'hAA;
        #1;
        chk("t6_ready_in_clear", bif.in_ready, 1);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bif.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t6_release", {ram_override, ram_nCS, ram_nWE}, 3'b011);
        chk("t6_flags", {bytes_written, done, range_err, abort_err}, 0);
        repeat (12) @(negedge clk);
        chk("t6_flushed", {bytes_written, ram_nCS}, {7'd0, 1'b1});

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
